// File: rtl/sound_player_pkg.sv
// Shared constants for the sound player: event codes, FSM states, default tone table.
package sound_pkg;

   typedef enum logic [2:0] {
      SND_NONE   = 3'd0,
      SND_WALL   = 3'd1,
      SND_HIT    = 3'd2,
      SND_BREAK  = 3'd3,
      SND_PADDLE = 3'd4
   } snd_code_e;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PLAY = 1'b1;

   localparam int unsigned DURATION_DEF = 5_000_000;
   localparam int unsigned HP_WALL_DEF   = 56_818;
   localparam int unsigned HP_HIT_DEF    = 47_801;
   localparam int unsigned HP_BREAK_DEF  = 37_936;
   localparam int unsigned HP_PADDLE_DEF = 95_420;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/sound_player_if.sv
// Ball-logic side of the sound player: event code and mute in, speaker and busy out.
interface sound_player_if;
   logic [2:0] sound_code;
   logic       mute;
   logic       speaker;
   logic       busy;

   modport master (output sound_code, output mute, input speaker, input busy);
   modport slave  (input sound_code, input mute, output speaker, output busy);
endinterface

// File: rtl/sound_player_tone_gen.sv
// Square-wave generator: reloads on load, toggles every half_period cycles while enabled.
module tone_gen #(
   parameter int W = 17
) (
   input  logic         clk_50mh,
   input  logic         reset,
   input  logic         load,
   input  logic [W:0]   half_period,
   input  logic         enable,
   output logic         out
);

   logic [W-1:0] hp_cnt_q, hp_cnt_d;
   logic         tone_q, tone_d;
   logic [W-1:0] reload;

   // half_period carries one extra bit so a power-of-two period still fits
   assign reload = W'(half_period - 1'b1);

   always_comb begin
      hp_cnt_d = hp_cnt_q;
      tone_d   = tone_q;
      if (load) begin
         hp_cnt_d = reload;
         tone_d   = 1'b0;
      end else if (enable) begin
         if (hp_cnt_q == '0) begin
            hp_cnt_d = reload;
            tone_d   = ~tone_q;
         end else begin
            hp_cnt_d = hp_cnt_q - 1'b1;
         end
      end else begin
         hp_cnt_d = '0;
         tone_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_50mh) begin
      if (reset) begin
         hp_cnt_q <= '0;
         tone_q   <= 1'b0;
      end else begin
         hp_cnt_q <= hp_cnt_d;
         tone_q   <= tone_d;
      end
   end

   assign out = tone_q;

endmodule

// File: rtl/sound_player.sv
// Turns ball-domain sound event codes into fixed-length square-wave tones on the speaker.
//   state | meaning
//   IDLE  | silent, waiting for a new code in 1..4
//   PLAY  | tone running, duration counter active; a new code restarts it
module sound_player
   import sound_pkg::*;
#(
   parameter int unsigned DURATION_CYCLES = DURATION_DEF,
   parameter int unsigned HP_1 = HP_WALL_DEF,
   parameter int unsigned HP_2 = HP_HIT_DEF,
   parameter int unsigned HP_3 = HP_BREAK_DEF,
   parameter int unsigned HP_4 = HP_PADDLE_DEF
) (
   input  logic          clk_50mh,
   input  logic          reset,
   sound_player_if.slave bus
);

   localparam int unsigned HP_MAX = max4(HP_1, HP_2, HP_3, HP_4);
   localparam int HP_W  = $clog2(HP_MAX);
   localparam int HPI_W = HP_W + 1;
   localparam int DUR_W = $clog2(DURATION_CYCLES);

   logic [2:0]       s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
   logic [0:0]       state_q, state_d;
   logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
   logic [HPI_W-1:0] hp_sel_q, hp_sel_d;
   logic             trigger;
   logic             tone;

   // Only a change of the synchronized level to a playable code starts a tone
   assign trigger = (s2_q != prev_q) && (s2_q >= 3'd1) && (s2_q <= 3'd4);

   always_comb begin
      s1_d      = bus.sound_code;
      s2_d      = s1_q;
      prev_d    = s2_q;
      hp_sel_d  = hp_sel_q;
      state_d   = state_q;
      dur_cnt_d = dur_cnt_q;
      if (trigger) begin
         case (s2_q)
            SND_WALL:  hp_sel_d = HPI_W'(HP_1);
            SND_HIT:   hp_sel_d = HPI_W'(HP_2);
            SND_BREAK: hp_sel_d = HPI_W'(HP_3);
            default:   hp_sel_d = HPI_W'(HP_4);
         endcase
         state_d   = PLAY;
         dur_cnt_d = DUR_W'(DURATION_CYCLES - 1);
      end else if (state_q == PLAY) begin
         if (dur_cnt_q == '0) state_d   = IDLE;
         else                 dur_cnt_d = dur_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_50mh) begin
      if (reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         prev_q    <= '0;
         state_q   <= IDLE;
         dur_cnt_q <= '0;
         hp_sel_q  <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         prev_q    <= prev_d;
         state_q   <= state_d;
         dur_cnt_q <= dur_cnt_d;
         hp_sel_q  <= hp_sel_d;
      end
   end

   // Enable follows the next state so the tone clears on the same edge busy falls
   tone_gen #(.W(HP_W)) u_tone_gen (
      .clk_50mh    (clk_50mh),
      .reset       (reset),
      .load        (trigger),
      .half_period (hp_sel_d),
      .enable      (state_d == PLAY),
      .out         (tone)
   );

   assign bus.speaker = tone & ~bus.mute;
   assign bus.busy    = (state_q == PLAY);

endmodule

// File: tb/tb_sound_player.sv
// Randomized and scripted bench for sound_player against an edge-indexed reference model.
module tb_sound_player;

   localparam int D = 20;
   localparam int HMAX = 8192;

   logic clk_50mh = 1'b0;
   logic reset    = 1'b1;
   sound_player_if bus();

   sound_player #(
      .DURATION_CYCLES (D),
      .HP_1 (3), .HP_2 (4), .HP_3 (5), .HP_4 (6)
   ) u_dut (
      .clk_50mh (clk_50mh),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 clk_50mh = ~clk_50mh;

   int n_tests = 0;
   int n_fail  = 0;

   int hist [HMAX];
   int t        = 0;
   int last_rst = 0;
   int e        = 0;
   int hp       = 1;
   bit e_valid  = 1'b0;

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, t, act, exp);
      end
   endtask

   function automatic int hp_of(input int c);
      case (c)
         1: return 3;
         2: return 4;
         3: return 5;
         default: return 6;
      endcase
   endfunction

   // value of the second sync stage right after edge x
   function automatic int s2_at(input int x);
      return (x - 1 > last_rst) ? hist[x-1] : 0;
   endfunction

   // value of the previous-code register right after edge x
   function automatic int prev_at(input int x);
      return (x > last_rst) ? s2_at(x - 1) : 0;
   endfunction

   task automatic model_edge();
      int c, p;
      c = s2_at(t - 1);
      p = prev_at(t - 1);
      if (c != p && c >= 1 && c <= 4) begin
         e       = t;
         hp      = hp_of(c);
         e_valid = 1'b1;
      end else if (e_valid && (t - e) >= D) begin
         e_valid = 1'b0;
      end
   endtask

   task automatic step(input int code, input bit m, input bit r);
      int exp_busy, exp_spk;
      bus.sound_code = 3'(code);
      bus.mute       = m;
      reset          = r;
      @(posedge clk_50mh);
      t++;
      hist[t] = code;
      if (r) begin
         last_rst = t;
         e_valid  = 1'b0;
      end else begin
         model_edge();
      end
      #1;
      exp_busy = (e_valid && (t - e) < D) ? 1 : 0;
      exp_spk  = (exp_busy == 1 && (((t - e) / hp) % 2) == 1 && !m) ? 1 : 0;
      chk("busy", int'(bus.busy), exp_busy);
      chk("speaker", int'(bus.speaker), exp_spk);
   endtask

   task automatic hold(input int code, input int n, input bit m);
      for (int i = 0; i < n; i++) step(code, m, 1'b0);
   endtask

   initial begin
      bus.sound_code = 3'd0;
      bus.mute       = 1'b0;
      for (int i = 0; i < HMAX; i++) hist[i] = 0;

      for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1);
      // basic tone: 0 -> 1
      hold(0, 3, 1'b0);
      hold(1, 30, 1'b0);
      // 1 -> 2 -> 2, second change lands exactly on duration expiry
      hold(0, 4, 1'b0);
      hold(1, 20, 1'b0);
      hold(2, 40, 1'b0);
      hold(1, 12, 1'b0);
      hold(2, 40, 1'b0);
      // preemption 3 -> 4 mid-tone
      hold(0, 5, 1'b0);
      hold(3, 10, 1'b0);
      hold(4, 30, 1'b0);
      // non-playable codes, then 2 interrupted by 6
      hold(0, 5, 1'b0);
      hold(5, 5, 1'b0);
      hold(7, 5, 1'b0);
      hold(0, 5, 1'b0);
      hold(2, 8, 1'b0);
      hold(6, 25, 1'b0);
      // muted tone, released mid-tone
      hold(0, 5, 1'b0);
      hold(4, 10, 1'b1);
      hold(4, 20, 1'b0);
      // reset in the middle of a held code-1 tone
      hold(0, 4, 1'b0);
      hold(1, 10, 1'b0);
      step(1, 1'b0, 1'b1);
      hold(1, 30, 1'b0);

      for (int k = 0; k < 150; k++) begin
         int code, n;
         bit m;
         code = $urandom_range(0, 7);
         n    = $urandom_range(1, 25);
         m    = ($urandom_range(0, 4) == 0);
         for (int j = 0; j < n; j++) step(code, m, ($urandom_range(0, 99) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
